// File: rtl/uart_pkg.sv
// Shared UART constants plus a constant-function log2 used to size FIFO pointers.
package uart_pkg;

  localparam int UART_DATA_W                = 8;
  localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int uart_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/consumer (master) and the RX FIFO (slave).
// Carries o_Level_IRQ only when UART_RX_FIFO_LEVEL_IRQ_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic [DATA_W-1:0] i_RX_Byte;
  logic              i_RX_Valid;
  logic              i_Ready;
  logic              i_Overrun_Clr;
  logic [DATA_W-1:0] o_Data;
  logic              o_Valid;
  logic [ADDR_W:0]   o_Count;
  logic              o_Empty;
  logic              o_Full;
  logic              o_Overrun;
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
  logic              o_Level_IRQ;
`endif

  modport master (
    output i_RX_Byte, i_RX_Valid, i_Ready, i_Overrun_Clr,
    input  o_Data, o_Valid, o_Count, o_Empty, o_Full, o_Overrun
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
    , input o_Level_IRQ
`endif
  );

  modport slave (
    input  i_RX_Byte, i_RX_Valid, i_Ready, i_Overrun_Clr,
    output o_Data, o_Valid, o_Count, o_Empty, o_Full, o_Overrun
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
    , output o_Level_IRQ
`endif
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally unreset; readers gate the output with the valid flag.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX byte buffer: edge-detected capture into a FWFT FIFO, 1-cycle push-to-valid, valid/ready pop.
// Drops bytes when full (sticky overrun); optional level IRQ under UART_RX_FIFO_LEVEL_IRQ_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = uart_clog2(DEPTH),
  parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
  , parameter int THRESHOLD = DEPTH / 2
`endif
) (
  input logic            i_Clk,
  input logic            i_Rst,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              r_Valid_d;
  logic              overrun;
  logic [DATA_W-1:0] head;

  logic valid;
  logic full;
  logic w_Push;
  logic w_Pop;
  logic wr_en;
  logic drop;

  assign valid  = (count != '0);
  assign full   = (count == FULL_CNT);
  assign w_Push = bus.i_RX_Valid & ~r_Valid_d;
  assign w_Pop  = valid & bus.i_Ready;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign wr_en = w_Push & (~full | w_Pop);
  assign drop  = w_Push & full & ~w_Pop;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      r_Valid_d <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_Valid_d <= bus.i_RX_Valid;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (w_Pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, w_Pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                   overrun <= 1'b1;
      else if (bus.i_Overrun_Clr) overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (i_Clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.i_RX_Byte),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.o_Data    = valid ? head : '0;
  assign bus.o_Valid   = valid;
  assign bus.o_Count   = count;
  assign bus.o_Empty   = ~valid;
  assign bus.o_Full    = full;
  assign bus.o_Overrun = overrun;

`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
  localparam logic [ADDR_W:0] THR_CNT = (ADDR_W + 1)'(THRESHOLD);

  logic level_irq;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) level_irq <= 1'b0;
    else       level_irq <= (count >= THR_CNT);
  end

  assign bus.o_Level_IRQ = level_irq;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single/long strobes, hand sequences for wrap, overrun, reset.
module tb_uart_rx_fifo;

  logic i_Clk;
  logic i_Rst;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_rx_fifo dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus.slave)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic [4:0] exp_count;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.i_RX_Byte  = b;
    bus.i_RX_Valid = 1'b1;
    tick();
    bus.i_RX_Valid = 1'b0;
    tick();
  endtask

  logic [7:0] exp_next;
  int         pushed;

  initial begin
    checks = 0;
    errors = 0;
    i_Rst  = 1'b1;
    bus.i_RX_Byte     = 8'h00;
    bus.i_RX_Valid    = 1'b0;
    bus.i_Ready       = 1'b0;
    bus.i_Overrun_Clr = 1'b0;
    tick();
    tick();

    chk("rst_valid",   32'(bus.o_Valid),   32'h0);
    chk("rst_empty",   32'(bus.o_Empty),   32'h1);
    chk("rst_full",    32'(bus.o_Full),    32'h0);
    chk("rst_count",   32'(bus.o_Count),   32'h0);
    chk("rst_data",    32'(bus.o_Data),    32'h0);
    chk("rst_overrun", 32'(bus.o_Overrun), 32'h0);
    i_Rst = 1'b0;
    tick();

    // Single byte, long strobe, push into empty FIFO with ready already high.
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 5'd1};
    vecs[1]  = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd1};
    vecs[2]  = '{8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0};
    vecs[3]  = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[4]  = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[5]  = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[6]  = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[7]  = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[8]  = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 5'd1};
    vecs[9]  = '{8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0};
    vecs[10] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 5'd1};
    vecs[11] = '{8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0};

    for (int v = 0; v < 12; v++) begin
      bus.i_RX_Byte  = vecs[v].rx_byte;
      bus.i_RX_Valid = vecs[v].rx_valid;
      bus.i_Ready    = vecs[v].ready;
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(bus.o_Valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_count", v), 32'(bus.o_Count), 32'(vecs[v].exp_count));
      chk($sformatf("vec%0d_empty", v), 32'(bus.o_Empty), 32'(vecs[v].exp_count == 5'd0));
      if (vecs[v].exp_valid)
        chk($sformatf("vec%0d_data", v), 32'(bus.o_Data), 32'(vecs[v].exp_data));
    end
    bus.i_RX_Valid = 1'b0;
    bus.i_Ready    = 1'b0;
    tick();

    // Fill 0x00..0x0F, then drain while pushing 0x10..0x17 across the pointer wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full",  32'(bus.o_Full),  32'h1);
    chk("fill_count", 32'(bus.o_Count), 32'd16);
    chk("fill_head",  32'(bus.o_Data),  32'h00);

    exp_next = 8'h00;
    pushed   = 0;
    for (int c = 0; c < 100 && exp_next < 8'h18; c++) begin
      bus.i_Ready    = 1'b1;
      bus.i_RX_Valid = ((c % 2) == 0) && (pushed < 8);
      bus.i_RX_Byte  = 8'(8'h10 + pushed);
      if (bus.i_RX_Valid) pushed++;
      if (bus.o_Valid) begin
        chk($sformatf("drain_%0h", exp_next), 32'(bus.o_Data), 32'(exp_next));
        exp_next = exp_next + 8'h01;
      end
      tick();
    end
    bus.i_Ready    = 1'b0;
    bus.i_RX_Valid = 1'b0;
    tick();
    chk("drain_total", 32'(exp_next), 32'h18);
    chk("drain_count", 32'(bus.o_Count), 32'd0);

    // Overrun: drop when full, accept with simultaneous pop, set beats clear.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    chk("ovr_full", 32'(bus.o_Full), 32'h1);
    push_byte(8'hEE);
    chk("ovr_set",   32'(bus.o_Overrun), 32'h1);
    chk("ovr_count", 32'(bus.o_Count),   32'd16);
    chk("ovr_head",  32'(bus.o_Data),    32'h80);

    bus.i_Overrun_Clr = 1'b1;
    tick();
    bus.i_Overrun_Clr = 1'b0;
    chk("ovr_clear", 32'(bus.o_Overrun), 32'h0);

    bus.i_RX_Byte  = 8'hF0;
    bus.i_RX_Valid = 1'b1;
    bus.i_Ready    = 1'b1;
    tick();
    bus.i_RX_Valid = 1'b0;
    bus.i_Ready    = 1'b0;
    tick();
    chk("pushpop_full_count",   32'(bus.o_Count),   32'd16);
    chk("pushpop_full_overrun", 32'(bus.o_Overrun), 32'h0);
    chk("pushpop_full_head",    32'(bus.o_Data),    32'h81);

    bus.i_RX_Byte     = 8'hEE;
    bus.i_RX_Valid    = 1'b1;
    bus.i_Overrun_Clr = 1'b1;
    tick();
    bus.i_RX_Valid    = 1'b0;
    bus.i_Overrun_Clr = 1'b0;
    chk("set_beats_clear", 32'(bus.o_Overrun), 32'h1);
    tick();

    // Drain, keep overrun sticky, then reset mid-stream with the strobe held high.
    bus.i_Ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.i_Ready = 1'b0;
    chk("drain2_count",  32'(bus.o_Count),   32'd0);
    chk("sticky_overrun", 32'(bus.o_Overrun), 32'h1);
    push_byte(8'h11);
    push_byte(8'h22);
    chk("pre_rst_count", 32'(bus.o_Count), 32'd2);

    bus.i_RX_Byte  = 8'h33;
    bus.i_RX_Valid = 1'b1;
    #2;
    i_Rst = 1'b1;
    #1;
    chk("async_rst_count",   32'(bus.o_Count),   32'd0);
    chk("async_rst_valid",   32'(bus.o_Valid),   32'h0);
    chk("async_rst_overrun", 32'(bus.o_Overrun), 32'h0);
    chk("async_rst_empty",   32'(bus.o_Empty),   32'h1);
    tick();
    i_Rst = 1'b0;
    tick();
    bus.i_RX_Valid = 1'b0;
    chk("post_rst_count", 32'(bus.o_Count), 32'd1);
    chk("post_rst_data",  32'(bus.o_Data),  32'h33);
    tick();
    chk("post_rst_single", 32'(bus.o_Count), 32'd1);

`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    tick();
    chk("irq_rst", 32'(bus.o_Level_IRQ), 32'h0);
    for (int i = 0; i < 7; i++) push_byte(8'(8'h40 + i));
    chk("irq_below", 32'(bus.o_Level_IRQ), 32'h0);
    push_byte(8'h47);
    chk("irq_count8", 32'(bus.o_Count), 32'd8);
    chk("irq_at_thr", 32'(bus.o_Level_IRQ), 32'h1);
    bus.i_Ready = 1'b1;
    tick();
    bus.i_Ready = 1'b0;
    tick();
    chk("irq_count7", 32'(bus.o_Count), 32'd7);
    chk("irq_drop", 32'(bus.o_Level_IRQ), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
